// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core. It tracks the
// instructions held in EX/MEM/WB, detects read-after-write hazards against
// the instruction in DEC, and drives stall, flush and operand forwarding
// selects. Stall and flush events are counted with saturating counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec_valid,
  input  logic [3:0]        dec_op,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [3:0]        ex_op,
  output logic [3:0]        mem_op,
  output logic [3:0]        wb_op,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [3:0] OP_ALUR   = 4'b1100;
  localparam logic [3:0] OP_ALUI   = 4'b0100;
  localparam logic [3:0] OP_LW     = 4'b0111;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_CMPR   = 4'b1101;
  localparam logic [3:0] OP_CMPI   = 4'b0101;
  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_JAL    = 4'b0110;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Opcode writes a destination register.
  function automatic logic op_writes(input logic [3:0] op);
    return (op == OP_ALUR) || (op == OP_ALUI) || (op == OP_LW) ||
           (op == OP_CMPR) || (op == OP_CMPI) || (op == OP_JAL);
  endfunction

  // Every defined opcode reads rs1; undefined opcodes read nothing.
  function automatic logic op_uses_rs1(input logic [3:0] op);
    return op_writes(op) || (op == OP_SW) || (op == OP_BRANCH);
  endfunction

  function automatic logic op_uses_rs2(input logic [3:0] op);
    return (op == OP_ALUR) || (op == OP_CMPR) || (op == OP_SW) || (op == OP_BRANCH);
  endfunction

  // Stage tracking registers
  logic              ex_valid_q, ex_valid_d, mem_valid_q, wb_valid_q;
  logic [3:0]        ex_op_q, ex_op_d, mem_op_q, wb_op_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic              ex_wr_q, ex_wr_d, mem_wr_q, wb_wr_q;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  state_t            state_q, state_d;

  logic use1, use2;
  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic ex_is_lw, hazard, flush_c, stall_c, bubble;

  // Source-use decode and per-stage producer matches against DEC sources.
  always_comb begin
    use1   = op_uses_rs1(dec_op);
    use2   = op_uses_rs2(dec_op);
    ex_m1  = ex_valid_q  & ex_wr_q  & (ex_rd_q  == dec_rs1) & use1;
    ex_m2  = ex_valid_q  & ex_wr_q  & (ex_rd_q  == dec_rs2) & use2;
    mem_m1 = mem_valid_q & mem_wr_q & (mem_rd_q == dec_rs1) & use1;
    mem_m2 = mem_valid_q & mem_wr_q & (mem_rd_q == dec_rs2) & use2;
    wb_m1  = wb_valid_q  & wb_wr_q  & (wb_rd_q  == dec_rs1) & use1;
    wb_m2  = wb_valid_q  & wb_wr_q  & (wb_rd_q  == dec_rs2) & use2;
  end

  // Hazard detection; a taken branch/JAL in EX overrides any stall.
  always_comb begin
    ex_is_lw = (ex_op_q == OP_LW);
    if (FWD_EN != 0) begin
      // Only a load in EX cannot be forwarded in time.
      hazard = dec_valid & ex_is_lw & (ex_m1 | ex_m2);
    end else begin
      hazard = dec_valid & (ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2);
    end
    flush_c = ex_valid_q & ex_br_taken & ((ex_op_q == OP_BRANCH) | (ex_op_q == OP_JAL));
    stall_c = hazard & ~flush_c;
    bubble  = flush_c | stall_c;
  end

  // Next EX contents and forwarding selects for the instruction entering EX.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_op_d    = 4'b0000;
    ex_rd_d    = '0;
    ex_wr_d    = 1'b0;
    fwd_a_d    = FWD_RF;
    fwd_b_d    = FWD_RF;
    if (!bubble && dec_valid) begin
      ex_valid_d = 1'b1;
      ex_op_d    = dec_op;
      ex_rd_d    = dec_rd;
      ex_wr_d    = op_writes(dec_op);
      if (FWD_EN != 0) begin
        // A non-load producer in EX will be in MEM next cycle; older ones in WB.
        if (ex_m1 && !ex_is_lw) fwd_a_d = FWD_MEM;
        else if (mem_m1)        fwd_a_d = FWD_WB;
        if (ex_m2 && !ex_is_lw) fwd_b_d = FWD_MEM;
        else if (mem_m2)        fwd_b_d = FWD_WB;
      end
    end
  end

  // Interlock FSM next state; a flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall_c)  state_d = ST_STALL;
      ST_STALL: if (!stall_c) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush_c) state_d = ST_RUN;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_c && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Pipeline tracking, forwarding, FSM and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= 4'b0000;
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_op_q    <= 4'b0000;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_op_q     <= 4'b0000;
      wb_rd_q     <= '0;
      wb_wr_q     <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      state_q     <= ST_RUN;
    end else begin
      wb_valid_q  <= mem_valid_q;
      wb_op_q     <= mem_op_q;
      wb_rd_q     <= mem_rd_q;
      wb_wr_q     <= mem_wr_q;
      mem_valid_q <= ex_valid_q;
      mem_op_q    <= ex_op_q;
      mem_rd_q    <= ex_rd_q;
      mem_wr_q    <= ex_wr_q;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      state_q     <= state_d;
    end
  end

  assign stall     = stall_c;
  assign flush     = flush_c;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;
  assign ex_op     = ex_op_q;
  assign mem_op    = mem_op_q;
  assign wb_op     = wb_op_q;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- REG_AW, 4: register index width.
- FWD_EN, 1: 1 = forwarding enabled; 0 = stall-only interlock.
- CNT_W, 16: width of the stall and flush event counters.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- dec_valid, in, 1: DEC stage holds a real instruction.
- dec_op, in, 4: DEC opcode. Encodings: ALUR 1100, ALUI 0100, LW 0111, SW 0011, CMPR 1101, CMPI 0101, BRANCH 0010, JAL 0110.
- dec_rs1, in, REG_AW: DEC source register 1.
- dec_rs2, in, REG_AW: DEC source register 2.
- dec_rd, in, REG_AW: DEC destination register.
- ex_br_taken, in, 1: EX-stage branch/JAL resolved as taken.
- stall, out, 1: hold PC and the IF/DEC latch.
- flush, out, 1: discard IF and DEC contents.
- ex_valid, mem_valid, wb_valid, out, 1 each: stage-valid flags.
- ex_op, mem_op, wb_op, out, 4 each: stage opcodes; 0000 when invalid.
- fwd_a, fwd_b, out, 2 each: EX operand source. 00 = regfile, 01 = MEM result, 10 = WB result.
- stall_cnt, flush_cnt, out, CNT_W each: event counters.

Function
REQ-003 Tracking registers per stage (EX, MEM, WB) SHALL hold {valid, op, rd, wr}.
- wr = 1 for ALUR, ALUI, LW, CMPR, CMPI, JAL; 0 for all other opcodes.
REQ-004 Source use:
- rs1 used by every defined opcode.
- rs2 used only by ALUR, CMPR, SW, BRANCH.
- An undefined opcode uses no source and has wr = 0.
REQ-005 Match(S, r) SHALL be S.valid & S.wr & (S.rd == r), with r a source used by DEC.
REQ-006 Hazard, FWD_EN=1: dec_valid & Match(EX, rs) & EX.op == LW, for any used source rs.
REQ-007 Hazard, FWD_EN=0: dec_valid & (Match(EX) | Match(MEM) | Match(WB)) on any used source.
REQ-008 stall SHALL be hazard & ~flush. It is combinational, asserted in the same cycle the hazard is present.
REQ-009 flush SHALL be ex_valid & ex_br_taken & (ex_op == BRANCH | ex_op == JAL). It is combinational. ex_br_taken is ignored in all other cases.
REQ-010 Each rising edge SHALL shift WB <= MEM and MEM <= EX, regardless of stall or flush.
REQ-011 EX loading at each rising edge:
- On flush or stall, EX SHALL load a bubble (valid = 0, op = 0000).
- Otherwise EX SHALL load {dec_valid, dec_op, dec_rd, wr(dec_op)}; op is forced to 0000 when dec_valid = 0.
REQ-012 fwd_a and fwd_b SHALL be registered alongside the EX load and evaluated against the pre-edge tracking state:
- 01 if Match(EX, rs) and EX.op != LW.
- else 10 if Match(MEM, rs).
- else 00.
- 00 whenever the EX load is a bubble, FWD_EN = 0, or the source is unused.
REQ-013 Interlock FSM states: RUN and STALL.
- RUN -> STALL on stall = 1.
- STALL -> RUN on stall = 0.
- flush SHALL force RUN on the next edge.
- The state is observable only through stall.
REQ-014 FWD_EN=1: a load-use stall SHALL last exactly 1 cycle. The consumer then enters EX with fwd = 10.
REQ-015 FWD_EN=0: stall SHALL persist until no producer remains in EX, MEM or WB; the maximum is 3 cycles.
REQ-016 flush and hazard in the same cycle: flush SHALL win. stall = 0, and the DEC instruction is discarded.
REQ-017 stall_cnt SHALL increment once per cycle with stall = 1; flush_cnt SHALL increment once per cycle with flush = 1. Both SHALL saturate at 2^CNT_W - 1 with no wrap.
REQ-018 rd/rs comparisons SHALL be full REG_AW-bit equality. Register 0 receives no special treatment.

Reset
REQ-019 When reset_n = 0, the block SHALL immediately (asynchronously) clear:
- all valid flags and ops, to 0;
- fwd_a and fwd_b, to 00;
- both counters, to 0;
- the FSM, to RUN.
REQ-020 During reset, stall and flush SHALL read 0.
REQ-021 Reset deassertion SHALL take effect at the first rising edge after reset_n goes high.
REQ-022 Reset asserted mid-stall or mid-flush SHALL abandon that operation with no residual bubble or count.

Verification
REQ-023 FWD_EN=1. Cycle 0: DEC = LW rd=3. Cycle 1: DEC = ALUR rs1=3.
- Cycle 1: stall = 1.
- Cycle 2: ex_valid = 0.
- Cycle 3: ex_op = 1100, fwd_a = 10.
- stall_cnt = 1.
REQ-024 FWD_EN=1, back-to-back ALUR (rd=5 then rs2=5) -> stall never asserts; the consumer enters EX with fwd_b = 01.
REQ-025 BRANCH in EX with ex_br_taken = 1 while DEC holds a load-use hazard:
- flush = 1 and stall = 0.
- Next cycle ex_valid = 0.
- flush_cnt = 1.
REQ-026 FWD_EN=0. ALUI rd=2, then CMPR rs1=2 -> stall = 1 for 3 consecutive cycles, then the consumer enters EX with fwd_a = 00.
REQ-027 CNT_W = 2, 5 load-use stalls -> stall_cnt reaches 3 and holds at 3.
REQ-028 reset_n pulsed low during a STALL cycle -> all outputs 0 at once; after release, with no DEC activity, stall = 0 and the counters stay 0.
